// File: rtl/ball_ctrl_pkg.sv
// Shared Pong geometry, FSM state codes and side encodings for the ball sequencer,
// game-control FSM and renderer.
package ball_ctrl_pkg;

  localparam int H_RES            = 640;
  localparam int V_RES            = 480;
  localparam int BALL_SIZE        = 8;
  localparam int PADDLE_W         = 8;
  localparam int PADDLE_H         = 64;
  localparam int L_PADDLE_X       = 16;
  localparam int R_PADDLE_X       = 616;
  localparam int INIT_SPEED       = 1;
  localparam int MAX_SPEED        = 4;
  localparam int HITS_PER_SPEEDUP = 4;

  localparam int L_FACE   = L_PADDLE_X + PADDLE_W;
  localparam int R_HIT_X  = R_PADDLE_X - BALL_SIZE;
  localparam int X_MAX    = H_RES - BALL_SIZE;
  localparam int Y_MAX    = V_RES - BALL_SIZE;
  localparam int X_CENTER = X_MAX / 2;
  localparam int Y_CENTER = Y_MAX / 2;

  localparam logic [2:0] ST_HOLD  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_MOVE  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DEAD  = 3'd4;

  localparam logic [1:0] SIDE_NONE  = 2'b00;
  localparam logic [1:0] SIDE_LEFT  = 2'b01;
  localparam logic [1:0] SIDE_RIGHT = 2'b10;

  // Signed headroom so a step past either screen edge stays representable.
  typedef logic signed [10:0] pos_t;

  function automatic pos_t step(input logic [9:0] p, input logic [2:0] spd,
                                input logic fwd);
    pos_t base;
    pos_t delta;
    base  = {1'b0, p};
    delta = {8'b0, spd};
    return fwd ? base + delta : base - delta;
  endfunction

endpackage

// File: rtl/ball_ctrl_paddle_overlap.sv
// Combinational test of whether the ball's rows intersect a paddle's rows.
module paddle_overlap
  import ball_ctrl_pkg::*;
(
  input  logic [9:0] ball_y_i,
  input  logic [9:0] paddle_y_i,
  output logic       overlap_o
);

  logic [10:0] ball_bot;
  logic [10:0] pad_bot;

  assign ball_bot  = {1'b0, ball_y_i} + 11'(BALL_SIZE);
  assign pad_bot   = {1'b0, paddle_y_i} + 11'(PADDLE_H);
  assign overlap_o = (ball_bot > {1'b0, paddle_y_i}) && ({1'b0, ball_y_i} < pad_bot);

endmodule

// File: rtl/ball_ctrl.sv
// Frame-synchronous ball motion: steps position once per frame, bounces off walls,
// reports paddle hits and misses, and ramps speed every few hits.
//
//   state    | meaning
//   HOLD     | ball parked at centre while the game FSM asserts restart
//   WAIT     | idle until the next endofframe pulse
//   MOVE     | compute next position, apply wall bounce on y
//   CHECK    | resolve paddle hit / miss, commit position, emit pulse
//   DEAD     | ball exited; frozen until restart
module ball_ctrl
  import ball_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       endofframe_i,
  input  logic       restart_i,
  input  logic [9:0] paddle_l_y_i,
  input  logic [9:0] paddle_r_y_i,
  output logic [9:0] ball_x_o,
  output logic [9:0] ball_y_o,
  output logic [1:0] collided_o,
  output logic [1:0] missed_o
);

  logic [2:0] state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d, ny_q, ny_d;
  pos_t       nx_q, nx_d, ny_move;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [2:0] speed_q, speed_d;
  logic [1:0] hit_cnt_q, hit_cnt_d;
  logic [1:0] collided_q, collided_d, missed_q, missed_d;
  logic       ovl_l, ovl_r, hit;

  paddle_overlap u_ovl_l (.ball_y_i(ny_q), .paddle_y_i(paddle_l_y_i), .overlap_o(ovl_l));
  paddle_overlap u_ovl_r (.ball_y_i(ny_q), .paddle_y_i(paddle_r_y_i), .overlap_o(ovl_r));

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    nx_d       = nx_q;
    ny_d       = ny_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    speed_d    = speed_q;
    hit_cnt_d  = hit_cnt_q;
    collided_d = SIDE_NONE;
    missed_d   = SIDE_NONE;
    hit        = 1'b0;
    ny_move    = step(y_q, speed_q, dir_y_q);

    case (state_q)
      ST_HOLD: begin
        x_d = 10'(X_CENTER);
        y_d = 10'(Y_CENTER);
        if (!restart_i) state_d = ST_WAIT;
      end
      ST_WAIT: if (endofframe_i) state_d = ST_MOVE;
      ST_MOVE: begin
        nx_d = step(x_q, speed_q, dir_x_q);
        ny_d = ny_move[9:0];
        if (ny_move <= pos_t'(0)) begin
          ny_d    = '0;
          dir_y_d = 1'b1;
        end else if (ny_move >= pos_t'(Y_MAX)) begin
          ny_d    = 10'(Y_MAX);
          dir_y_d = 1'b0;
        end
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        y_d     = ny_q;
        state_d = ST_WAIT;
        // Hits require the ball to start on the playfield side of the face,
        // so a ball already past a paddle cannot be pulled back.
        if (!dir_x_q && x_q >= 10'(L_FACE) && nx_q <= pos_t'(L_FACE) && ovl_l) begin
          x_d        = 10'(L_FACE);
          dir_x_d    = 1'b1;
          collided_d = SIDE_LEFT;
          hit        = 1'b1;
        end else if (dir_x_q && x_q <= 10'(R_HIT_X) && nx_q >= pos_t'(R_HIT_X) && ovl_r) begin
          x_d        = 10'(R_HIT_X);
          dir_x_d    = 1'b0;
          collided_d = SIDE_RIGHT;
          hit        = 1'b1;
        end else if (nx_q <= pos_t'(0)) begin
          x_d      = '0;
          dir_x_d  = 1'b0;
          missed_d = SIDE_LEFT;
          state_d  = ST_DEAD;
        end else if (nx_q >= pos_t'(X_MAX)) begin
          x_d      = 10'(X_MAX);
          dir_x_d  = 1'b1;
          missed_d = SIDE_RIGHT;
          state_d  = ST_DEAD;
        end else begin
          x_d = nx_q[9:0];
        end
        if (hit) begin
          if (hit_cnt_q == 2'(HITS_PER_SPEEDUP - 1)) begin
            hit_cnt_d = '0;
            if (speed_q < 3'(MAX_SPEED)) speed_d = speed_q + 3'd1;
          end else begin
            hit_cnt_d = hit_cnt_q + 2'd1;
          end
        end
      end
      ST_DEAD: ;
      default: state_d = ST_HOLD;
    endcase

    if (restart_i) begin
      state_d    = ST_HOLD;
      x_d        = 10'(X_CENTER);
      y_d        = 10'(Y_CENTER);
      speed_d    = 3'(INIT_SPEED);
      hit_cnt_d  = '0;
      dir_x_d    = dir_x_q;
      collided_d = SIDE_NONE;
      missed_d   = SIDE_NONE;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_HOLD;
      x_q        <= 10'(X_CENTER);
      y_q        <= 10'(Y_CENTER);
      nx_q       <= '0;
      ny_q       <= '0;
      dir_x_q    <= 1'b1;
      dir_y_q    <= 1'b1;
      speed_q    <= 3'(INIT_SPEED);
      hit_cnt_q  <= '0;
      collided_q <= SIDE_NONE;
      missed_q   <= SIDE_NONE;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      nx_q       <= nx_d;
      ny_q       <= ny_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      speed_q    <= speed_d;
      hit_cnt_q  <= hit_cnt_d;
      collided_q <= collided_d;
      missed_q   <= missed_d;
    end
  end

  assign ball_x_o   = x_q;
  assign ball_y_o   = y_q;
  assign collided_o = collided_q;
  assign missed_o   = missed_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl: idle, stepping, wall bounce, paddle hit, miss,
// speed ramp and restart during CHECK.
module tb_ball_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       eof;
  logic       restart;
  logic [9:0] pl_y, pr_y;
  logic [9:0] ball_x, ball_y;
  logic [1:0] collided, missed;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ball_ctrl dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .endofframe_i (eof),
    .restart_i    (restart),
    .paddle_l_y_i (pl_y),
    .paddle_r_y_i (pr_y),
    .ball_x_o     (ball_x),
    .ball_y_o     (ball_y),
    .collided_o   (collided),
    .missed_o     (missed)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame: pulse endofframe in WAIT, sample outputs 3 cycles later and
  // again one cycle after that to confirm pulses are single-cycle.
  task automatic frame(output int fx, output int fy, output int fc, output int fm,
                       output int fc2, output int fm2);
    @(negedge clk) eof = 1'b1;
    @(negedge clk) eof = 1'b0;
    @(negedge clk);
    @(negedge clk);
    fx = ball_x; fy = ball_y; fc = collided; fm = missed;
    @(negedge clk);
    fc2 = collided; fm2 = missed;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; restart = 1'b0; eof = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  int fx, fy, fc, fm, fc2, fm2;
  int spur, hits, prev_x, last_y, dx, exp_dx, chk_next, found;

  initial begin
    rst_n = 1'b0; restart = 1'b1; eof = 1'b0; pl_y = '0; pr_y = '0;

    // idle with restart held
    #12;
    chk("rst_x", ball_x, 316);
    chk("rst_y", ball_y, 236);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) frame(fx, fy, fc, fm, fc2, fm2);
    chk("idle_x", fx, 316);
    chk("idle_y", fy, 236);
    chk("idle_pulses", fc | fm, 0);

    // single step
    @(negedge clk) restart = 1'b0;
    frame(fx, fy, fc, fm, fc2, fm2);
    chk("step_x", fx, 317);
    chk("step_y", fy, 237);
    chk("step_pulses", fc | fm, 0);

    // wall bounce then right-paddle hit
    do_reset();
    pr_y = 10'd400; pl_y = 10'd0; spur = 0;
    for (int f = 1; f <= 293; f++) begin
      frame(fx, fy, fc, fm, fc2, fm2);
      if (f == 236) chk("bounce_y", fy, 472);
      if (f == 237) chk("bounce_flip_y", fy, 471);
      if (f == 292) begin
        chk("rhit_x", fx, 608);
        chk("rhit_y", fy, 416);
        chk("rhit_coll", fc, 2);
        chk("rhit_coll_width", fc2, 0);
      end else if (fc != 0 || fm != 0) spur++;
      if (f == 293) chk("rhit_after_x", fx, 607);
    end
    chk("t3_spurious", spur, 0);

    // right miss, freeze, restart
    do_reset();
    pr_y = 10'd0;
    for (int f = 1; f <= 319; f++) begin
      frame(fx, fy, fc, fm, fc2, fm2);
      if (f == 292) chk("miss_nohit_coll", fc, 0);
      if (f == 316) begin
        chk("miss_x", fx, 632);
        chk("miss_y", fy, 392);
        chk("miss_pulse", fm, 2);
        chk("miss_pulse_width", fm2, 0);
      end
    end
    chk("dead_x", fx, 632);
    chk("dead_y", fy, 392);
    chk("dead_pulses", fc | fm, 0);
    @(negedge clk) restart = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("restart_x", ball_x, 316);
    chk("restart_y", ball_y, 236);
    // asynchronous reset takes effect without a clock edge
    restart = 1'b0;
    frame(fx, fy, fc, fm, fc2, fm2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_x", ball_x, 316);
    chk("async_rst_y", ball_y, 236);
    @(negedge clk) rst_n = 1'b1;

    // speed ramp with paddles tracking the ball
    do_reset();
    hits = 0; prev_x = 316; last_y = 236; chk_next = 0; exp_dx = 0;
    for (int f = 0; f < 6000 && hits < 16; f++) begin
      pl_y = (last_y >= 28) ? 10'(last_y - 28) : 10'd0;
      pr_y = pl_y;
      frame(fx, fy, fc, fm, fc2, fm2);
      dx = (fx > prev_x) ? fx - prev_x : prev_x - fx;
      if (chk_next != 0) begin
        chk("speed_dx", dx, exp_dx);
        chk_next = 0;
      end
      if (fm != 0) chk("speed_unexpected_miss", fm, 0);
      if (fc != 0) begin
        hits++;
        if (hits == 4) begin
          chk("speed_hit_pos", fx, (fc == 1) ? 24 : 608);
          chk_next = 1; exp_dx = 2;
        end
        if (hits == 12) begin chk_next = 1; exp_dx = 4; end
        if (hits == 16) begin chk_next = 1; exp_dx = 4; end
      end
      prev_x = fx; last_y = fy;
    end
    chk("speed_hits", hits, 16);
    pl_y = (last_y >= 28) ? 10'(last_y - 28) : 10'd0;
    pr_y = pl_y;
    frame(fx, fy, fc, fm, fc2, fm2);
    dx = (fx > prev_x) ? fx - prev_x : prev_x - fx;
    chk("speed_sat_dx", dx, exp_dx);
    prev_x = fx; last_y = fy;

    // approach right paddle at speed 4, then restart during the hit's CHECK
    found = 0;
    for (int f = 0; f < 400 && found == 0; f++) begin
      pl_y = (last_y >= 28) ? 10'(last_y - 28) : 10'd0;
      pr_y = pl_y;
      frame(fx, fy, fc, fm, fc2, fm2);
      if (fx > prev_x && fx >= 604 && fx < 608 && fc == 0) found = 1;
      prev_x = fx; last_y = fy;
    end
    chk("approach_found", found, 1);
    pl_y = (last_y >= 28) ? 10'(last_y - 28) : 10'd0;
    pr_y = pl_y;
    @(negedge clk) eof = 1'b1;
    @(negedge clk) eof = 1'b0;
    @(negedge clk) restart = 1'b1;
    @(negedge clk);
    chk("midrst_x", ball_x, 316);
    chk("midrst_y", ball_y, 236);
    chk("midrst_coll", collided, 0);
    restart = 1'b0;
    @(negedge clk);
    chk("midrst_coll_late", collided, 0);
    frame(fx, fy, fc, fm, fc2, fm2);
    chk("midrst_speed_x", fx, 317);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
